// File: rtl/reconciled_key_reader_if.sv
// Key stream from the reconciled-key reader to privacy amplification:
// one 64-bit word per valid/ready handshake, tlast marks the final word of a frame.
interface reconciled_key_reader_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] key_tdata;
  logic              key_tvalid;
  logic              key_tready;
  logic              key_tlast;

  modport master (output key_tdata, output key_tvalid, output key_tlast, input key_tready);
  modport slave  (input key_tdata, input key_tvalid, input key_tlast, output key_tready);
endinterface

// File: rtl/reconciled_key_reader.sv
// Port-B reader of the reconciled-key RAM ring: queues frame descriptors, streams good
// frames word by word with their header, discards failed frames, and releases each slot.
`ifndef FRAME_LEAKED_INFO_WIDTH
`define FRAME_LEAKED_INFO_WIDTH 16
`endif
`ifndef FRAME_ERROR_COUNT_WIDTH
`define FRAME_ERROR_COUNT_WIDTH 16
`endif

module reconciled_key_reader #(
  parameter int FRAME_WORDS = 64,
  parameter int NUM_FRAMES  = 8,
  parameter int LEAK_W      = `FRAME_LEAKED_INFO_WIDTH,
  parameter int ERR_W       = `FRAME_ERROR_COUNT_WIDTH,
  parameter int QDEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEAK_W-1:0]       frame_leaked_info,
  input  logic [ERR_W-1:0]        frame_error_count,
  input  logic                    frame_verification_fail,
  input  logic                    frame_parameter_valid,
  output logic                    keyram_clkb,
  output logic                    keyram_enb,
  output logic [14:0]             keyram_addrb,
  input  logic [63:0]             keyram_doutb,
  reconciled_key_reader_if.master key,
  output logic [LEAK_W-1:0]       hdr_leaked_info,
  output logic [ERR_W-1:0]        hdr_error_count,
  output logic                    frame_consumed,
  output logic                    busy,
  output logic                    queue_overflow,
  output logic [15:0]             frames_read,
  output logic [15:0]             frames_skipped
);

  localparam int IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int SLOT_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int QW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FRAMES - 1);
  localparam logic [QW:0]       Q_FULL    = (QW+1)'(QDEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_DRAIN, S_SKIP} state_t;

  typedef struct packed {
    logic [LEAK_W-1:0] leaked;
    logic [ERR_W-1:0]  errcnt;
    logic              fail;
  } desc_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } word_t;

  state_t            state, state_next;

  desc_t             q_mem [QDEPTH];
  desc_t             q_head;
  logic [QW-1:0]     q_wr, q_rd;
  logic [QW:0]       q_count;
  logic              q_push, q_pop, q_avail;

  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0]  word_idx;
  logic              credit, rd_issue, rd_pending, rd_last;

  word_t             ob_mem [2];
  logic              ob_wr, ob_rd;
  logic [1:0]        ob_occ;
  logic              tvalid, ob_pop, last_hs, consume;

  assign keyram_clkb = clk;

  // ---------------------------------------------------------------------------
  // Descriptor queue
  // ---------------------------------------------------------------------------
  assign q_head  = q_mem[q_rd];
  assign q_push  = frame_parameter_valid && ((q_count != Q_FULL) || q_pop);
  // A strobe this cycle counts as pending work so IDLE reaches LOAD one cycle later.
  assign q_avail = (q_count != '0) || frame_parameter_valid;

  // NOTE: storage arrays carry no reset; only pointers/count are reset, which keeps
  // the array in plain RAM cells and is enough because nothing reads an empty slot.
  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr] <= desc_t'({frame_leaked_info, frame_error_count,
                                        frame_verification_fail});
  end

  // NOTE: all state registers use non-blocking assignments so every always_ff reads
  // the pre-edge value of every other register, independent of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr           <= '0;
      q_rd           <= '0;
      q_count        <= '0;
      queue_overflow <= 1'b0;
    end else begin
      if (q_push) q_wr <= q_wr + 1'b1;
      if (q_pop)  q_rd <= q_rd + 1'b1;
      q_count <= q_count + (QW+1)'(q_push) - (QW+1)'(q_pop);
      if (frame_parameter_valid && !q_push) queue_overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register, next-state logic, output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (q_avail) state_next = S_LOAD;
      S_LOAD:  state_next = q_head.fail ? S_SKIP : S_READ;
      S_READ:  if (rd_issue && (word_idx == LAST_IDX)) state_next = S_DRAIN;
      S_DRAIN: if (last_hs) state_next = q_avail ? S_LOAD : S_IDLE;
      S_SKIP:  state_next = q_avail ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    q_pop    = (state == S_LOAD);
    rd_issue = (state == S_READ) && credit;
    consume  = (state == S_SKIP) || ((state == S_DRAIN) && last_hs);
  end

  // ---------------------------------------------------------------------------
  // Read issue: a word may be requested only if the 2-entry buffer will have room
  // for it when it returns, counting words already in flight.
  // ---------------------------------------------------------------------------
  assign credit       = (3'(ob_occ) + 3'(rd_pending)) < (3'd2 + 3'(ob_pop));
  assign keyram_enb   = rd_issue;
  assign keyram_addrb = rd_issue ? (15'(slot) * 15'(FRAME_WORDS)) + 15'(word_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot            <= '0;
      word_idx        <= '0;
      rd_pending      <= 1'b0;
      rd_last         <= 1'b0;
      hdr_leaked_info <= '0;
      hdr_error_count <= '0;
      frame_consumed  <= 1'b0;
      frames_read     <= '0;
      frames_skipped  <= '0;
    end else begin
      rd_pending     <= rd_issue;
      rd_last        <= rd_issue && (word_idx == LAST_IDX);
      frame_consumed <= consume;
      if (q_pop) begin
        hdr_leaked_info <= q_head.leaked;
        hdr_error_count <= q_head.errcnt;
        word_idx        <= '0;
      end else if (rd_issue) begin
        word_idx <= word_idx + 1'b1;
      end
      if (consume) slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      if (consume && state == S_DRAIN) frames_read    <= frames_read + 16'd1;
      if (consume && state == S_SKIP)  frames_skipped <= frames_skipped + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer: RAM data lands here the cycle after issue; the head entry drives
  // the stream and stays put until accepted.
  // ---------------------------------------------------------------------------
  assign tvalid         = (ob_occ != 2'd0);
  assign ob_pop         = tvalid && key.key_tready;
  assign last_hs        = ob_pop && ob_mem[ob_rd].last;
  assign key.key_tvalid = tvalid;
  assign key.key_tdata  = tvalid ? ob_mem[ob_rd].data : '0;
  assign key.key_tlast  = tvalid && ob_mem[ob_rd].last;

  always_ff @(posedge clk) begin
    if (rd_pending) ob_mem[ob_wr] <= '{data: keyram_doutb, last: rd_last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ob_wr  <= 1'b0;
      ob_rd  <= 1'b0;
      ob_occ <= 2'd0;
    end else begin
      if (rd_pending) ob_wr <= ~ob_wr;
      if (ob_pop)     ob_rd <= ~ob_rd;
      ob_occ <= ob_occ + 2'(rd_pending) - 2'(ob_pop);
    end
  end

endmodule
